// File: rtl/dsi_pkt_tx.sv
// dsi_pkt_tx -- MIPI DSI packet builder (byte stream).
//
// Builds one framed DSI packet per accepted command:
//   DI, WC[7:0], WC[15:8], ECC [, payload[0..WC-1], CRC[7:0], CRC[15:8]]
// ECC (Hamming, 6 bits) covers {WC, DI}. The payload CRC-16 is the reflected
// 0x8408 polynomial, init 0xFFFF, no final XOR. After each packet's last byte is
// accepted, GAP_CYCLES idle cycles pass before the next command is taken.
//
// Ports:
//   clk, rst                 system clock, asynchronous active-high reset
//   cmd_valid/cmd_ready      command handshake; cmd_long, cmd_di, cmd_wc latched on accept
//   pl_valid/pl_ready/pl_data payload byte stream (consumed only in PAY)
//   tx_valid/tx_ready/tx_data output byte stream, tx_sop on DI, tx_eop on last byte
//   busy                     high whenever the builder is not IDLE
module dsi_pkt_tx #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_long,
    input  logic [7:0]  cmd_di,
    input  logic [15:0] cmd_wc,
    input  logic        pl_valid,
    output logic        pl_ready,
    input  logic [7:0]  pl_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [7:0]  tx_data,
    output logic        tx_sop,
    output logic        tx_eop,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_PAY,
        S_CRC,
        S_GAP
    } state_t;

    state_t      state_q;
    logic [1:0]  idx_q;
    logic        long_q;
    logic [7:0]  di_q;
    logic [15:0] wc_q;
    logic [15:0] cnt_q;
    logic [15:0] crc_q;
    logic [7:0]  gap_q;
    logic        cmd_ready_q;
    logic        tx_valid_q;
    logic [7:0]  tx_data_q;
    logic        tx_sop_q;
    logic        tx_eop_q;

    logic        adv;
    logic [7:0]  ecc_d;
    logic [15:0] crc_d;

    function automatic logic [7:0] dsi_ecc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
        return {2'b00, p};
    endfunction

    // One byte of the reflected CRC-16, LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] b);
        logic [15:0] c;
        c = crc ^ {8'h00, b};
        for (int unsigned i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
        end
        return c;
    endfunction

    // The output register may load a new byte only when it is empty or being taken.
    assign adv   = !tx_valid_q || tx_ready;
    assign ecc_d = dsi_ecc({wc_q, di_q});
    assign crc_d = crc16_byte(crc_q, pl_data);

    assign cmd_ready = cmd_ready_q;
    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign tx_sop    = tx_sop_q;
    assign tx_eop    = tx_eop_q;
    assign busy      = (state_q != S_IDLE);
    assign pl_ready  = (state_q == S_PAY) && adv && (cnt_q != 16'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            long_q      <= 1'b0;
            di_q        <= '0;
            wc_q        <= '0;
            cnt_q       <= '0;
            crc_q       <= '1;
            gap_q       <= '0;
            cmd_ready_q <= 1'b0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            tx_sop_q    <= 1'b0;
            tx_eop_q    <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    // First cycle out of reset only raises cmd_ready.
                    if (!cmd_ready_q) begin
                        cmd_ready_q <= 1'b1;
                    end else if (cmd_valid) begin
                        cmd_ready_q <= 1'b0;
                        long_q      <= cmd_long;
                        di_q        <= cmd_di;
                        wc_q        <= cmd_wc;
                        crc_q       <= '1;
                        tx_valid_q  <= 1'b1;
                        tx_data_q   <= cmd_di;
                        tx_sop_q    <= 1'b1;
                        tx_eop_q    <= 1'b0;
                        idx_q       <= 2'd1;
                        state_q     <= S_HDR;
                    end
                end

                S_HDR: begin
                    if (adv) begin
                        tx_valid_q <= 1'b1;
                        tx_sop_q   <= 1'b0;
                        idx_q      <= idx_q + 2'd1;
                        case (idx_q)
                            2'd1:    tx_data_q <= wc_q[7:0];
                            2'd2:    tx_data_q <= wc_q[15:8];
                            default: begin
                                tx_data_q <= ecc_d;
                                tx_eop_q  <= !long_q;
                                if (!long_q) begin
                                    state_q <= S_GAP;
                                    gap_q   <= 8'(GAP_CYCLES);
                                end else if (wc_q != 16'd0) begin
                                    state_q <= S_PAY;
                                    cnt_q   <= wc_q;
                                end else begin
                                    state_q <= S_CRC;
                                    idx_q   <= 2'd0;
                                end
                            end
                        endcase
                    end
                end

                S_PAY: begin
                    if (pl_ready && pl_valid) begin
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= pl_data;
                        crc_q      <= crc_d;
                        cnt_q      <= cnt_q - 16'd1;
                        if (cnt_q == 16'd1) begin
                            state_q <= S_CRC;
                            idx_q   <= 2'd0;
                        end
                    end else if (adv) begin
                        // Payload underrun: emit a bubble, CRC untouched.
                        tx_valid_q <= 1'b0;
                    end
                end

                S_CRC: begin
                    if (adv) begin
                        tx_valid_q <= 1'b1;
                        if (idx_q == 2'd0) begin
                            tx_data_q <= crc_q[7:0];
                            idx_q     <= 2'd1;
                        end else begin
                            tx_data_q <= crc_q[15:8];
                            tx_eop_q  <= 1'b1;
                            state_q   <= S_GAP;
                            gap_q     <= 8'(GAP_CYCLES);
                        end
                    end
                end

                S_GAP: begin
                    // The eop byte may still be waiting in the output register;
                    // the idle count only runs once it has been taken.
                    if (tx_valid_q) begin
                        if (tx_ready) begin
                            tx_valid_q <= 1'b0;
                            tx_eop_q   <= 1'b0;
                            if (GAP_CYCLES == 0) begin
                                state_q     <= S_IDLE;
                                cmd_ready_q <= 1'b1;
                            end
                        end
                    end else if (gap_q <= 8'd1) begin
                        state_q     <= S_IDLE;
                        cmd_ready_q <= 1'b1;
                    end else begin
                        gap_q <= gap_q - 8'd1;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dsi_pkt_tx.sv
module tb_dsi_pkt_tx;

    localparam int unsigned TB_GAP = 3;

    logic        clk;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_long;
    logic [7:0]  cmd_di;
    logic [15:0] cmd_wc;
    logic        pl_valid;
    logic        pl_ready;
    logic [7:0]  pl_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_sop;
    logic        tx_eop;
    logic        busy;

    int unsigned checks   = 0;
    int unsigned failures = 0;

    logic [9:0]  exp_q [$];   // {sop, eop, data}
    logic [7:0]  pay [0:511];
    logic        rdy_rand = 1'b0;

    dsi_pkt_tx #(.GAP_CYCLES(TB_GAP)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_long  (cmd_long),
        .cmd_di    (cmd_di),
        .cmd_wc    (cmd_wc),
        .pl_valid  (pl_valid),
        .pl_ready  (pl_ready),
        .pl_data   (pl_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .tx_data   (tx_data),
        .tx_sop    (tx_sop),
        .tx_eop    (tx_eop),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Downstream ready: always 1, or random when rdy_rand is set.
    initial begin : ready_driver
        tx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_ready = rdy_rand ? 1'($urandom_range(0, 99) < 60) : 1'b1;
        end
    end

    // Scoreboard: every accepted output byte is compared with the queue head;
    // a stalled byte must be held unchanged into the next cycle.
    initial begin : monitor
        logic       stall;
        logic [9:0] stall_v;
        logic [9:0] e;
        stall = 1'b0;
        stall_v = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall) begin
                    checks++;
                    if (!tx_valid || {tx_sop, tx_eop, tx_data} !== stall_v) begin
                        failures++;
                        $display("FAIL stall_hold got valid=%b %h exp valid=1 %h", tx_valid, {tx_sop, tx_eop, tx_data}, stall_v);
                    end
                end
                stall   = tx_valid && !tx_ready;
                stall_v = {tx_sop, tx_eop, tx_data};
                if (tx_valid && tx_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_byte got sop/eop/data=%h exp none", {tx_sop, tx_eop, tx_data});
                    end else begin
                        e = exp_q.pop_front();
                        if ({tx_sop, tx_eop, tx_data} !== e) begin
                            failures++;
                            $display("FAIL byte got sop/eop/data=%h exp %h", {tx_sop, tx_eop, tx_data}, e);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2ms;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic push_b(input logic sop, input logic eop, input logic [7:0] d);
        exp_q.push_back({sop, eop, d});
    endtask

    // Reference packet model: ECC from per-bit parity masks, CRC bitwise.
    task automatic push_pkt(input logic lng, input logic [7:0] di, input logic [15:0] wc);
        logic [23:0] d;
        logic [7:0]  ecc;
        logic [15:0] crc;
        d   = {wc, di};
        ecc = {2'b00, ^(d & 24'hEFFC00), ^(d & 24'hDF03F0), ^(d & 24'hB8E38E),
                      ^(d & 24'h749A6D), ^(d & 24'hF2555B), ^(d & 24'hF12CB7)};
        push_b(1'b1, 1'b0, di);
        push_b(1'b0, 1'b0, wc[7:0]);
        push_b(1'b0, 1'b0, wc[15:8]);
        push_b(1'b0, !lng, ecc);
        if (lng) begin
            crc = 16'hFFFF;
            for (int i = 0; i < int'(wc); i++) begin
                push_b(1'b0, 1'b0, pay[i]);
                crc = crc ^ {8'h00, pay[i]};
                for (int b = 0; b < 8; b++) crc = crc[0] ? ((crc >> 1) ^ 16'h8408) : (crc >> 1);
            end
            push_b(1'b0, 1'b0, crc[7:0]);
            push_b(1'b0, 1'b1, crc[15:8]);
        end
    endtask

    // Returns in the cycle after acceptance; cmd_* are scrambled afterwards.
    task automatic send_cmd(input logic lng, input logic [7:0] di, input logic [15:0] wc);
        int unsigned t;
        @(posedge clk);
        #1;
        cmd_valid = 1'b1;
        cmd_long  = lng;
        cmd_di    = di;
        cmd_wc    = wc;
        t = 0;
        @(negedge clk);
        while (!cmd_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!cmd_ready) begin
            failures++;
            $display("FAIL cmd_accept got cmd_ready=0 exp 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_long  = ~lng;
        cmd_di    = ~di;
        cmd_wc    = ~wc;
    endtask

    task automatic drive_payload(input int unsigned n, input int unsigned bubble_pct);
        int unsigned i;
        int unsigned guard;
        i = 0;
        guard = 0;
        while (i < n && guard < 20000) begin
            @(posedge clk);
            #1;
            pl_valid = ($urandom_range(0, 99) >= bubble_pct);
            pl_data  = pay[i];
            @(negedge clk);
            if (pl_valid && pl_ready) i++;
            guard++;
        end
        checks++;
        if (i != n) begin
            failures++;
            $display("FAIL payload_accept got %0d exp %0d bytes", i, n);
        end
        @(posedge clk);
        #1;
        pl_valid = 1'b0;
    endtask

    task automatic wait_drain(input int unsigned max_cycles);
        int unsigned t;
        t = 0;
        while ((exp_q.size() != 0 || busy) && t < max_cycles) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_long  = 1'b0;
        cmd_di    = '0;
        cmd_wc    = '0;
        pl_valid  = 1'b0;
        pl_data   = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_ready, pl_ready, tx_valid, tx_sop, tx_eop, busy, tx_data} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs got %b exp 0", {cmd_ready, pl_ready, tx_valid, tx_sop, tx_eop, busy, tx_data});
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0) begin
            failures++;
            $display("FAIL ready_at_release got %b exp 0", cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ready_after_reset got ready=%b busy=%b exp ready=1 busy=0", cmd_ready, busy);
        end
    endtask

    task automatic test_short();
        push_b(1'b1, 1'b0, 8'h05);
        push_b(1'b0, 1'b0, 8'h11);
        push_b(1'b0, 1'b0, 8'h00);
        push_b(1'b0, 1'b1, 8'h36);
        send_cmd(1'b0, 8'h05, 16'h0011);
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL short_drain got %0d exp 0 pending", exp_q.size());
        end
    endtask

    task automatic test_short_gap();
        int unsigned t;
        logic [15:0] hist;
        push_b(1'b1, 1'b0, 8'h05);
        push_b(1'b0, 1'b0, 8'h29);
        push_b(1'b0, 1'b0, 8'h00);
        push_b(1'b0, 1'b1, 8'h1C);
        send_cmd(1'b0, 8'h05, 16'h0029);
        @(negedge clk);
        checks++;
        if (!(tx_valid && tx_sop && tx_data == 8'h05)) begin
            failures++;
            $display("FAIL di_latency got valid=%b sop=%b data=%h exp 1 1 05", tx_valid, tx_sop, tx_data);
        end
        t = 0;
        while (!(tx_valid && tx_ready && tx_eop) && t < 50) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t != 3) begin
            failures++;
            $display("FAIL short_length got eop at +%0d exp +3", t);
        end
        hist = '0;
        for (int k = 0; k <= int'(TB_GAP); k++) begin
            @(negedge clk);
            hist[k] = cmd_ready;
        end
        checks++;
        if (hist !== (16'h1 << TB_GAP)) begin
            failures++;
            $display("FAIL gap_ready got %b exp %b", hist, 16'h1 << TB_GAP);
        end
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL gap_drain got %0d exp 0 pending", exp_q.size());
        end
    endtask

    task automatic test_long9();
        int unsigned n;
        int unsigned t;
        logic        done;
        for (int i = 0; i < 9; i++) pay[i] = 8'h31 + 8'(i);
        push_b(1'b1, 1'b0, 8'h39);
        push_b(1'b0, 1'b0, 8'h09);
        push_b(1'b0, 1'b0, 8'h00);
        push_b(1'b0, 1'b0, 8'h30);
        for (int i = 0; i < 9; i++) push_b(1'b0, 1'b0, pay[i]);
        push_b(1'b0, 1'b0, 8'h91);
        push_b(1'b0, 1'b1, 8'h6F);
        fork
            drive_payload(9, 0);
        join_none
        send_cmd(1'b1, 8'h39, 16'd9);
        n = 0;
        t = 0;
        done = 1'b0;
        while (!done && t < 100) begin
            @(negedge clk);
            t++;
            if (tx_valid) begin
                n++;
                if (tx_ready && tx_eop) done = 1'b1;
            end else if (n > 0) begin
                done = 1'b1;
            end
        end
        checks++;
        if (n != 15) begin
            failures++;
            $display("FAIL long9_valid_cycles got %0d exp 15", n);
        end
        wait fork;
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL long9_drain got %0d exp 0 pending", exp_q.size());
        end
    endtask

    task automatic test_long_wc0();
        push_b(1'b1, 1'b0, 8'h29);
        push_b(1'b0, 1'b0, 8'h00);
        push_b(1'b0, 1'b0, 8'h00);
        push_b(1'b0, 1'b0, 8'h1C);
        push_b(1'b0, 1'b0, 8'hFF);
        push_b(1'b0, 1'b1, 8'hFF);
        send_cmd(1'b1, 8'h29, 16'd0);
        wait_drain(100);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL wc0_drain got %0d exp 0 pending", exp_q.size());
        end
    endtask

    task automatic test_back_to_back_stress();
        for (int i = 0; i < 256; i++) pay[i] = 8'($urandom_range(0, 255));
        push_pkt(1'b1, 8'h79, 16'd256);
        rdy_rand = 1'b1;
        fork
            drive_payload(256, 30);
        join_none
        send_cmd(1'b1, 8'h79, 16'd256);
        wait fork;
        wait_drain(3000);
        rdy_rand = 1'b0;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL stress_drain got %0d exp 0 pending", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 20; i++) pay[i] = 8'hA5;
        push_pkt(1'b1, 8'h29, 16'd20);
        @(posedge clk);
        #1;
        pl_valid = 1'b1;
        pl_data  = 8'hA5;
        send_cmd(1'b1, 8'h29, 16'd20);
        @(negedge clk);
        checks++;
        if (pl_ready !== 1'b0 || tx_sop !== 1'b1) begin
            failures++;
            $display("FAIL pl_ready_in_hdr got pl_ready=%b sop=%b exp 0 1", pl_ready, tx_sop);
        end
        repeat (6) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, pl_ready, tx_valid, tx_sop, tx_eop, busy, tx_data} !== 14'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs got %b exp 0", {cmd_ready, pl_ready, tx_valid, tx_sop, tx_eop, busy, tx_data});
        end
        exp_q.delete();
        pl_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b0 || tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_release got ready=%b valid=%b exp 0 0", cmd_ready, tx_valid);
        end
        @(negedge clk);
        checks++;
        if (cmd_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_reset_ready got %b exp 1", cmd_ready);
        end
        test_short();
    endtask

    initial begin
        test_reset();
        test_short();
        test_short_gap();
        test_long9();
        test_long_wc0();
        test_back_to_back_stress();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
